switch_debounce_toggle: RTL and testbench
=========================================

Name: switch_debounce_toggle

Overview:
Input-side conditioner for raw board switches. It synchronises one mechanical switch into i_Clk, debounces it with a stability counter, and emits one-cycle press/release pulses, a toggle-on-release LED drive and a wrapping press counter. It sits between a board switch pin and downstream LED/LUT logic, so consumers see clean levels and edges instead of bouncing raw input.

Parameters:
DEBOUNCE_LIMIT, 250000, cycles sync'd input must differ from debounced state before it is accepted (10 ms at 25 MHz); legal range 2..2^20-1
COUNT_WIDTH, 8, width of o_Press_Count

Ports:
i_Clk  input  1  system clock, all logic on rising edge
i_Rst  input  1  synchronous reset, active-high
i_Switch  input  1  raw asynchronous switch pin, 1 = pressed
o_Switch_Debounced  output  1  debounced switch level
o_Press_Pulse  output  1  one-cycle pulse on debounced 0->1
o_Release_Pulse  output  1  one-cycle pulse on debounced 1->0
o_LED  output  1  toggles on each release
o_Press_Count  output  COUNT_WIDTH  number of accepted presses, wraps

Behaviour:
- Interface: one clock, i_Clk; reset i_Rst is synchronous and active-high.
- Reset (i_Rst=1 at a rising edge): both synchroniser flops, stability counter, o_Switch_Debounced, o_Press_Pulse, o_Release_Pulse, o_LED = 0, o_Press_Count = 0. Reset dominates all other events on that edge. Reset mid-count discards the partial count. Switch held high through reset is accepted as a fresh press DEBOUNCE_LIMIT+2 edges after reset deasserts.
- Synchroniser: two-flop chain, sync1 <= i_Switch, sync2 <= sync1. Only sync2 is used downstream.
- Stability counter, ceil(log2(DEBOUNCE_LIMIT)) bits:
  - sync2 == debounced state: counter <= 0.
  - sync2 != state and counter < DEBOUNCE_LIMIT-1: counter <= counter+1.
  - sync2 != state and counter == DEBOUNCE_LIMIT-1: state <= sync2, counter <= 0.
  - Any return to equality before the limit clears the counter. No partial credit; a bounce restarts the count.
- Latency: a clean input step is first sampled by sync1 at edge k. o_Switch_Debounced changes at edge k+DEBOUNCE_LIMIT+1, which is DEBOUNCE_LIMIT+2 edges inclusive.
- Pulses are registered on the same edge the state flips and are high for exactly that one following cycle:
  - 0->1 flip: o_Press_Pulse=1; o_Press_Count <= o_Press_Count+1, wrapping 2^COUNT_WIDTH-1 -> 0.
  - 1->0 flip: o_Release_Pulse=1; o_LED <= ~o_LED on the same edge.
- Press and release pulses are never high in the same cycle. Minimum spacing between any two pulses is DEBOUNCE_LIMIT cycles.
- No FSM beyond this state bit and counter. No combinational path from i_Switch to any output.

Test Plan (DEBOUNCE_LIMIT=4, COUNT_WIDTH=8):
1. Reset with i_Switch=0, hold 10 cycles -> all outputs 0, no pulses.
2. i_Switch 0->1 held clean before edge k -> o_Switch_Debounced=1 and o_Press_Pulse=1 at edge k+5 only; o_Press_Count=1; o_LED stays 0.
3. From pressed, i_Switch 1->0 held -> o_Release_Pulse one cycle at edge k+5; o_LED 0->1; count unchanged at 1.
4. Bounce: i_Switch toggles 1,0,1,0 each 2 cycles, then steady 1 -> no pulse during bounce; single press pulse 6 edges after the final steady edge is first sampled.
5. 256 clean press/release pairs from reset -> o_Press_Count wraps to 0; o_LED=0 (even number of toggles); 256 press and 256 release pulses counted.
6. Assert i_Rst for 1 cycle with counter at 2 while i_Switch=1 and debounced=0 -> all outputs 0, no pulse; after release, press accepted exactly 6 edges later.

Source files
------------

// File: rtl/switch_debounce_toggle_if.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce_toggle_if
//  Description : Signal bundle between a raw board switch and its conditioner.
//                The slave side is the conditioner. The master side is the
//                switch source that consumes the conditioned outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface switch_debounce_toggle_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   i_Switch;
  logic                   o_Switch_Debounced;
  logic                   o_Press_Pulse;
  logic                   o_Release_Pulse;
  logic                   o_LED;
  logic [COUNT_WIDTH-1:0] o_Press_Count;

  modport master (
    output i_Switch,
    input  o_Switch_Debounced,
    input  o_Press_Pulse,
    input  o_Release_Pulse,
    input  o_LED,
    input  o_Press_Count
  );

  modport slave (
    input  i_Switch,
    output o_Switch_Debounced,
    output o_Press_Pulse,
    output o_Release_Pulse,
    output o_LED,
    output o_Press_Count
  );
endinterface
`default_nettype wire

// File: rtl/switch_debounce_toggle.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce_toggle
//  Description : Synchronises and debounces one mechanical switch. Emits
//                one-cycle press/release pulses, a toggle-on-release LED
//                drive and a wrapping press counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce_toggle #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int COUNT_WIDTH    = 8
) (
  input  wire logic              i_Clk,
  input  wire logic              i_Rst,
  switch_debounce_toggle_if.slave sw_if
);

  // Width is just enough to hold DEBOUNCE_LIMIT-1, which is the terminal count.
  localparam int                c_CNT_W    = $clog2(DEBOUNCE_LIMIT);
  localparam logic [c_CNT_W-1:0] c_LIMIT_M1 = c_CNT_W'(DEBOUNCE_LIMIT - 1);

  logic                   r_sync1;
  logic                   r_sync2;
  logic [c_CNT_W-1:0]     r_stable_cnt;
  logic                   r_debounced;
  logic                   r_press_pulse;
  logic                   r_release_pulse;
  logic                   r_led;
  logic [COUNT_WIDTH-1:0] r_press_count;

  logic w_differs;
  logic w_accept;

  // The synchronised input disagrees with the accepted level and has held that
  // disagreement for the full window. The level is taken on this edge.
  assign w_differs = (r_sync2 != r_debounced);
  assign w_accept  = w_differs && (r_stable_cnt == c_LIMIT_M1);

  // Two-flop synchroniser that brings the asynchronous pin into the clock domain.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sw_if.i_Switch;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter. Any agreement clears it, so a bounce restarts the window.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_stable_cnt <= '0;
      r_debounced  <= 1'b0;
    end else if (!w_differs || w_accept) begin
      r_stable_cnt <= '0;
      if (w_accept) begin
        r_debounced <= r_sync2;
      end
    end else begin
      r_stable_cnt <= r_stable_cnt + 1'b1;
    end
  end

  // Edge pulses, LED toggle and press count, all registered on the flip edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_led           <= 1'b0;
      r_press_count   <= '0;
    end else begin
      r_press_pulse   <= w_accept &&  r_sync2;
      r_release_pulse <= w_accept && !r_sync2;
      if (w_accept && r_sync2) begin
        r_press_count <= r_press_count + 1'b1;
      end
      if (w_accept && !r_sync2) begin
        r_led <= ~r_led;
      end
    end
  end

  assign sw_if.o_Switch_Debounced = r_debounced;
  assign sw_if.o_Press_Pulse      = r_press_pulse;
  assign sw_if.o_Release_Pulse    = r_release_pulse;
  assign sw_if.o_LED              = r_led;
  assign sw_if.o_Press_Count      = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_toggle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_debounce_toggle
//  Description : Self-checking bench for switch_debounce_toggle. It compares
//                the DUT against a window-based reference model. The model
//                accepts a new level once the last DEBOUNCE_LIMIT synchronised
//                samples all disagree with the current level.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debounce_toggle;

  localparam int LIM = 4;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  switch_debounce_toggle_if #(.COUNT_WIDTH(CW)) bus ();

  switch_debounce_toggle #(
    .DEBOUNCE_LIMIT(LIM),
    .COUNT_WIDTH   (CW)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .sw_if (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int press_seen;
  int rel_seen;

  // Reference model state. q holds the input samples of the last LIM+1 edges,
  // oldest first. The newest sample has not reached the second synchroniser
  // stage yet, so only the first LIM entries count toward acceptance.
  bit m_deb, m_press, m_rel, m_led;
  int m_cnt;
  bit q[$];

  function automatic void model_reset_hist();
    q.delete();
    for (int i = 0; i < LIM + 1; i++) q.push_back(1'b0);
  endfunction

  function automatic void model_edge(input bit r, input bit s);
    bit all_diff;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (r) begin
      m_deb = 1'b0;
      m_led = 1'b0;
      m_cnt = 0;
      model_reset_hist();
    end else begin
      all_diff = 1'b1;
      for (int i = 0; i < LIM; i++) if (q[i] == m_deb) all_diff = 1'b0;
      if (all_diff) begin
        m_deb = ~m_deb;
        if (m_deb) begin
          m_press = 1'b1;
          m_cnt   = (m_cnt + 1) % (1 << CW);
        end else begin
          m_rel = 1'b1;
          m_led = ~m_led;
        end
      end
      q.push_back(s);
      void'(q.pop_front());
    end
  endfunction

  function automatic logic [CW+3:0] obs();
    return {bus.o_Switch_Debounced, bus.o_Press_Pulse, bus.o_Release_Pulse,
            bus.o_LED, bus.o_Press_Count};
  endfunction

  function automatic logic [CW+3:0] expv();
    return {m_deb, m_press, m_rel, m_led, 8'(m_cnt)};
  endfunction

  // Apply one clock edge with the given reset/switch, advance the model and
  // leave the outputs settled 1 time unit after the edge.
  task automatic tick(input bit r, input bit s);
    rst          = r;
    bus.i_Switch = s;
    @(posedge clk);
    model_edge(r, s);
    #1;
    press_seen += int'(bus.o_Press_Pulse);
    rel_seen   += int'(bus.o_Release_Pulse);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      n_checks++;
      if (obs() !== 12'h000) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got %h need 000", i, obs());
      end
    end
  endtask

  task automatic test_press();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1);
      n_checks++;
      if (obs() !== expv() || bus.o_Press_Pulse !== (i == 5)) begin
        n_fail++;
        $display("FAIL press edge%0d: got %h need %h", i, obs(), expv());
      end
    end
    n_checks++;
    if (bus.o_Press_Count !== 8'd1 || bus.o_LED !== 1'b0 || bus.o_Switch_Debounced !== 1'b1) begin
      n_fail++;
      $display("FAIL press_final: got cnt=%0d led=%b deb=%b need 1 0 1",
               bus.o_Press_Count, bus.o_LED, bus.o_Switch_Debounced);
    end
  endtask

  task automatic test_release();
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0);
      n_checks++;
      if (obs() !== expv() || bus.o_Release_Pulse !== (i == 5)) begin
        n_fail++;
        $display("FAIL release edge%0d: got %h need %h", i, obs(), expv());
      end
    end
    n_checks++;
    if (bus.o_Press_Count !== 8'd1 || bus.o_LED !== 1'b1) begin
      n_fail++;
      $display("FAIL release_final: got cnt=%0d led=%b need 1 1", bus.o_Press_Count, bus.o_LED);
    end
  endtask

  task automatic test_bounce();
    bit lvl;
    for (int i = 0; i < 8; i++) begin
      lvl = (i % 4) < 2;
      tick(1'b0, lvl);
      n_checks++;
      if (obs() !== expv() || bus.o_Press_Pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce cyc%0d: got %h need %h", i, obs(), expv());
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1);
      n_checks++;
      if (obs() !== expv() || bus.o_Press_Pulse !== (i == 5)) begin
        n_fail++;
        $display("FAIL bounce_settle edge%0d: got %h need %h", i, obs(), expv());
      end
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    tick(1'b1, 1'b0);
    press_seen = 0;
    rel_seen   = 0;
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 14; i++) begin
        tick(1'b0, i < 7);
        if (obs() !== expv()) begin
          n_checks++;
          n_fail++;
          $display("FAIL wrap pair%0d cyc%0d: got %h need %h", p, i, obs(), expv());
        end
      end
    end
    n_checks++;
    if (bus.o_Press_Count !== 8'd0 || bus.o_LED !== 1'b0 || press_seen != 256 || rel_seen != 256) begin
      n_fail++;
      $display("FAIL wrap_final: got cnt=%0d led=%b press=%0d rel=%0d need 0 0 256 256",
               bus.o_Press_Count, bus.o_LED, press_seen, rel_seen);
    end
  endtask

  task automatic test_reset_midcount();
    tick(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    n_checks++;
    if (obs() !== 12'h000) begin
      n_fail++;
      $display("FAIL midcount_reset: got %h need 000", obs());
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1);
      n_checks++;
      if (obs() !== expv() || bus.o_Press_Pulse !== (i == 5)) begin
        n_fail++;
        $display("FAIL midcount_after edge%0d: got %h need %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    bit lvl = 1'b0;
    bit r;
    int run;
    tick(1'b1, 1'b0);
    for (int k = 0; k < 300; k++) begin
      lvl = ~lvl;
      run = $urandom_range(1, 9);
      for (int i = 0; i < run; i++) begin
        r = ($urandom_range(0, 79) == 0);
        tick(r, lvl);
        n_checks++;
        if (obs() !== expv() || (bus.o_Press_Pulse && bus.o_Release_Pulse)) begin
          n_fail++;
          $display("FAIL random run%0d cyc%0d: got %h need %h", k, i, obs(), expv());
        end
      end
    end
  endtask

  initial begin
    bus.i_Switch = 1'b0;
    press_seen   = 0;
    rel_seen     = 0;
    model_reset_hist();
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_wrap();
    test_reset_midcount();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
